dht11_sched: RTL and testbench

Measurement scheduler for the DHT11 temperature/humidity path. Periodically commands the DHT11 one-wire transceiver through a start/done handshake, validates each returned 40-bit frame by checksum, retries failed reads, and publishes the last good temperature/humidity bytes. Also drives page selection (humidity / temperature / error) for the 4-digit 7-segment display mux.

---
 rtl/dht11_pkg.sv | 31 +++
 rtl/dht11_chk.sv | 26 ++
 rtl/dht11_sched.sv | 213 +++++++++++++++++++++
 tb/tb_dht11_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 measurement scheduler: display page codes,
// scheduler state encoding, frame byte positions and the checksum helper.
package dht11_pkg;

  localparam logic [1:0] PG_HUM  = 2'b00;
  localparam logic [1:0] PG_TEMP = 2'b01;
  localparam logic [1:0] PG_ERR  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_CHECK     = 3'd3,
    ST_GAP       = 3'd4,
    ST_HOLD      = 3'd5
  } state_t;

  // LSB position of each byte inside the 40-bit sensor frame
  localparam int unsigned FRM_HUM_INT  = 32;
  localparam int unsigned FRM_HUM_DEC  = 24;
  localparam int unsigned FRM_TEMP_INT = 16;
  localparam int unsigned FRM_TEMP_DEC = 8;
  localparam int unsigned FRM_CSUM     = 0;

  // DHT11 checksum: plain 8-bit wrapping sum of the four data bytes
  function automatic logic [7:0] byte_sum(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
    return a + b + c + d;
  endfunction

endpackage

// File: rtl/dht11_chk.sv
// Combinational frame check: splits a DHT11 frame into its bytes and reports
// whether the transmitted checksum matches the data.
module dht11_chk
  import dht11_pkg::*;
(
  input  logic [39:0] frame_i,
  output logic [7:0]  hum_int_o,
  output logic [7:0]  temp_int_o,
  output logic        ok_o
);

  logic [7:0] w_hum_dec;
  logic [7:0] w_temp_dec;
  logic [7:0] w_csum;
  logic [7:0] w_sum;

  assign hum_int_o  = frame_i[FRM_HUM_INT  +: 8];
  assign w_hum_dec  = frame_i[FRM_HUM_DEC  +: 8];
  assign temp_int_o = frame_i[FRM_TEMP_INT +: 8];
  assign w_temp_dec = frame_i[FRM_TEMP_DEC +: 8];
  assign w_csum     = frame_i[FRM_CSUM     +: 8];

  assign w_sum = byte_sum(hum_int_o, w_hum_dec, temp_int_o, w_temp_dec);
  assign ok_o  = (w_sum == w_csum);

endmodule

// File: rtl/dht11_sched.sv
// DHT11 measurement scheduler: launches periodic reads through the
// transceiver handshake, retries failed attempts, publishes the last good
// temperature/humidity bytes and selects the display page.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   IDLE       | waiting for en_i=1 and busy_i=0 to begin a new read cycle
//   START      | req_o pulse to the transceiver (one cycle)
//   WAIT_DONE  | waiting for done_i, bounded by the timeout timer
//   CHECK      | checksum verdict of the captured frame (one cycle)
//   GAP        | sensor recovery time before a retry
//   HOLD       | waiting out the remainder of the measurement period
//
// All timers are down-counters loaded at the start of their interval and
// stopped at zero. The timeout timer is loaded as req_o is raised, so its
// terminal count lands exactly TIMEOUT_CYC cycles after req_o. The period
// timer is loaded one short because leaving HOLD costs an IDLE cycle, which
// keeps scheduled req_o pulses exactly PERIOD_CYC apart.
module dht11_sched
  import dht11_pkg::*;
#(
  parameter int unsigned PERIOD_CYC    = 100000000,
  parameter int unsigned TIMEOUT_CYC   = 2500000,
  parameter int unsigned RETRY_GAP_CYC = 50000000,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned PAGE_CYC      = 134217728
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic        req_o,
  input  logic        busy_i,
  input  logic        done_i,
  input  logic [39:0] frame_i,
  output logic [7:0]  temp_o,
  output logic [7:0]  hum_o,
  output logic        valid_o,
  output logic        upd_o,
  output logic        fail_o,
  output logic [7:0]  err_cnt_o,
  output logic [1:0]  page_o,
  output logic        led_o
);

  localparam int unsigned PER_W = $clog2(PERIOD_CYC);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);
  localparam int unsigned GAP_W = $clog2(RETRY_GAP_CYC);
  localparam int unsigned PG_W  = $clog2(PAGE_CYC);
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);

  localparam logic [PER_W-1:0] PER_LOAD = PER_W'(PERIOD_CYC - 2);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(RETRY_GAP_CYC - 1);
  localparam logic [PG_W-1:0]  PG_LOAD  = PG_W'(PAGE_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  state_t           r_state;
  logic             r_req;
  logic             r_led;
  logic             r_upd;
  logic             r_valid;
  logic             r_fail;
  logic             r_good;
  logic [7:0]       r_temp;
  logic [7:0]       r_hum;
  logic [7:0]       r_err_cnt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [PER_W-1:0] r_per_cnt;
  logic [RTY_W-1:0] r_retry;
  logic             r_pg_sel;
  logic [PG_W-1:0]  r_pg_cnt;

  logic [7:0]       w_hum;
  logic [7:0]       w_temp;
  logic             w_ok;
  logic             w_fail_att;
  logic             w_show;

  dht11_chk u_chk (
    .frame_i    (frame_i),
    .hum_int_o  (w_hum),
    .temp_int_o (w_temp),
    .ok_o       (w_ok)
  );

  // An attempt fails on a timeout with no simultaneous done_i, or on a bad checksum
  assign w_fail_att = ((r_state == ST_WAIT_DONE) && !done_i && (r_tmo_cnt == '0)) ||
                      ((r_state == ST_CHECK) && !r_good);

  // Scheduler FSM with registered handshake, status and published data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_req     <= 1'b0;
      r_led     <= 1'b0;
      r_upd     <= 1'b0;
      r_valid   <= 1'b0;
      r_fail    <= 1'b0;
      r_good    <= 1'b0;
      r_temp    <= '0;
      r_hum     <= '0;
      r_err_cnt <= '0;
      r_tmo_cnt <= '0;
      r_gap_cnt <= '0;
      r_per_cnt <= '0;
      r_retry   <= '0;
    end else begin
      r_req <= 1'b0;
      r_upd <= 1'b0;
      if (r_per_cnt != '0) r_per_cnt <= r_per_cnt - PER_W'(1);

      unique case (r_state)
        ST_IDLE: begin
          if (en_i && !busy_i) begin
            r_state   <= ST_START;
            r_req     <= 1'b1;
            r_led     <= 1'b1;
            r_tmo_cnt <= TMO_LOAD;
            r_per_cnt <= PER_LOAD;
            r_retry   <= '0;
          end
        end
        ST_START: begin
          r_state <= ST_WAIT_DONE;
          if (r_tmo_cnt != '0) r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
        end
        ST_WAIT_DONE: begin
          // Good frames are published on the capture edge so upd_o lines up
          // with the CHECK cycle; CHECK then only routes on the verdict.
          if (done_i) begin
            r_state <= ST_CHECK;
            r_led   <= 1'b0;
            r_good  <= w_ok;
            if (w_ok) begin
              r_temp  <= w_temp;
              r_hum   <= w_hum;
              r_upd   <= 1'b1;
              r_valid <= 1'b1;
              r_fail  <= 1'b0;
              r_retry <= '0;
            end
          end else if (r_tmo_cnt != '0) begin
            r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
          end
        end
        ST_CHECK: begin
          if (r_good) r_state <= ST_HOLD;
        end
        ST_GAP: begin
          if (!en_i) begin
            r_state <= ST_IDLE;
          end else if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end else if (!busy_i) begin
            r_state   <= ST_START;
            r_req     <= 1'b1;
            r_led     <= 1'b1;
            r_tmo_cnt <= TMO_LOAD;
          end
        end
        ST_HOLD: begin
          // A period already used up by retries leaves HOLD on its first cycle
          if (r_per_cnt == '0) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_fail_att) begin
        r_led <= 1'b0;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        if (r_retry < RTY_MAX) begin
          r_retry   <= r_retry + RTY_W'(1);
          r_gap_cnt <= GAP_LOAD;
          r_state   <= ST_GAP;
        end else begin
          r_fail  <= 1'b1;
          r_retry <= '0;
          r_state <= ST_HOLD;
        end
      end
    end
  end

  assign w_show = r_valid && !r_fail;

  // Page alternation; restarts on the humidity page whenever data becomes showable
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pg_sel <= 1'b0;
      r_pg_cnt <= '0;
    end else if (!w_show) begin
      r_pg_sel <= 1'b0;
      r_pg_cnt <= PG_LOAD;
    end else if (r_pg_cnt == '0) begin
      r_pg_sel <= ~r_pg_sel;
      r_pg_cnt <= PG_LOAD;
    end else begin
      r_pg_cnt <= r_pg_cnt - PG_W'(1);
    end
  end

  assign page_o    = !w_show ? PG_ERR : (r_pg_sel ? PG_TEMP : PG_HUM);
  assign req_o     = r_req;
  assign led_o     = r_led;
  assign upd_o     = r_upd;
  assign valid_o   = r_valid;
  assign fail_o    = r_fail;
  assign temp_o    = r_temp;
  assign hum_o     = r_hum;
  assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_dht11_sched.sv
// Bench for dht11_sched: plays the transceiver side and predicts request
// timing, published data, error counts and display page from the
// scheduler's behavioural rules.
module tb_dht11_sched;

  localparam int PERIOD = 200;
  localparam int TMO    = 20;
  localparam int GAP    = 10;
  localparam int MAXR   = 3;
  localparam int PAGE   = 50;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic        req_o;
  logic        busy_i;
  logic        done_i;
  logic [39:0] frame_i;
  logic [7:0]  temp_o;
  logic [7:0]  hum_o;
  logic        valid_o;
  logic        upd_o;
  logic        fail_o;
  logic [7:0]  err_cnt_o;
  logic [1:0]  page_o;
  logic        led_o;

  dht11_sched #(
    .PERIOD_CYC    (PERIOD),
    .TIMEOUT_CYC   (TMO),
    .RETRY_GAP_CYC (GAP),
    .MAX_RETRY     (MAXR),
    .PAGE_CYC      (PAGE)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (en_i),
    .req_o     (req_o),
    .busy_i    (busy_i),
    .done_i    (done_i),
    .frame_i   (frame_i),
    .temp_o    (temp_o),
    .hum_o     (hum_o),
    .valid_o   (valid_o),
    .upd_o     (upd_o),
    .fail_o    (fail_o),
    .err_cnt_o (err_cnt_o),
    .page_o    (page_o),
    .led_o     (led_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int         m_next_req;
  int         m_tol;
  int         m_cyc_start;
  int         m_retry;
  int         m_show_t;
  bit         m_valid;
  bit         m_fail;
  logic [7:0] m_temp;
  logic [7:0] m_hum;
  logic [7:0] m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step();
  endtask

  function automatic logic [1:0] exp_page();
    if (!m_valid || m_fail) return 2'b10;
    return ((((cyc - m_show_t) / PAGE) % 2) != 0) ? 2'b01 : 2'b00;
  endfunction

  function automatic logic [39:0] mk_frame(input bit good);
    logic [7:0] h, hd, t, td, cs;
    h  = 8'($urandom);
    hd = 8'($urandom);
    t  = 8'($urandom);
    td = 8'($urandom);
    cs = h + hd + t + td;
    if (!good) cs = cs + 8'($urandom_range(1, 255));
    return {h, hd, t, td, cs};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_fail = 0; m_retry = 0;
    m_temp = 8'h00; m_hum = 8'h00; m_err = 8'h00;
  endtask

  task automatic wait_req(output int t);
    for (int i = 0; i < 260; i++) begin
      step();
      if (req_o) break;
    end
    chk("req_seen", 32'(req_o), 32'd1);
    t = cyc;
  endtask

  task automatic fail_update();
    m_err = (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1;
    if (m_retry < MAXR) begin
      m_retry++;
      m_next_req = cyc + GAP;
    end else begin
      m_fail = 1;
      m_retry = 0;
      m_next_req = m_cyc_start + PERIOD;
    end
    chk("err_cnt", 32'(err_cnt_o), 32'(m_err));
    chk("fail", 32'(fail_o), 32'(m_fail));
    chk("page_fail", 32'(page_o), 32'(exp_page()));
    chk("temp_hold", 32'(temp_o), 32'(m_temp));
    chk("hum_hold", 32'(hum_o), 32'(m_hum));
  endtask

  // kind 0: done_i d cycles after req_o carrying frm; kind 1: no response
  task automatic do_attempt(input int kind, input int d, input logic [39:0] frm, input bit drop_en);
    int t0;
    logic [7:0] s;
    wait_req(t0);
    if (!req_o) return;
    if (m_tol != 0)
      chk("req_latency_ok", 32'((t0 >= m_next_req) && (t0 <= m_next_req + m_tol)), 32'd1);
    else
      chk("req_time", 32'(t0), 32'(m_next_req));
    m_tol = 0;
    if (m_retry == 0) m_cyc_start = t0;
    chk("led_on", 32'(led_o), 32'd1);
    chk("page_at_req", 32'(page_o), 32'(exp_page()));
    step();
    chk("req_one_cycle", 32'(req_o), 32'd0);
    if (drop_en) begin
      step_to(t0 + 2);
      en_i = 1'b0;
    end
    if (kind == 0 && d <= TMO) begin
      step_to(t0 + d - 1);
      done_i = 1'b1;
      frame_i = frm;
      step();
      done_i = 1'b0;
      frame_i = {$urandom, 8'($urandom)};
      chk("led_off_done", 32'(led_o), 32'd0);
      s = frm[39:32] + frm[31:24] + frm[23:16] + frm[15:8];
      if (s == frm[7:0]) begin
        m_temp = frm[23:16];
        m_hum  = frm[39:32];
        if (!m_valid || m_fail) m_show_t = cyc;
        m_valid = 1;
        m_fail = 0;
        m_retry = 0;
        m_next_req = m_cyc_start + PERIOD;
        chk("upd_pulse", 32'(upd_o), 32'd1);
        chk("temp", 32'(temp_o), 32'(m_temp));
        chk("hum", 32'(hum_o), 32'(m_hum));
        chk("valid", 32'(valid_o), 32'd1);
        chk("fail_clear", 32'(fail_o), 32'd0);
        chk("page_pub", 32'(page_o), 32'(exp_page()));
        step();
        chk("upd_one_cycle", 32'(upd_o), 32'd0);
      end else begin
        chk("upd_bad", 32'(upd_o), 32'd0);
        step();
        fail_update();
      end
    end else begin
      step_to(t0 + TMO - 1);
      chk("led_before_tmo", 32'(led_o), 32'd1);
      step();
      chk("led_after_tmo", 32'(led_o), 32'd0);
      fail_update();
      if (kind == 0) begin
        step_to(t0 + d - 1);
        done_i = 1'b1;
        frame_i = frm;
        step();
        done_i = 1'b0;
        chk("late_done_ignored", 32'(upd_o), 32'd0);
        chk("late_err_cnt", 32'(err_cnt_o), 32'(m_err));
      end
    end
  endtask

  initial begin
    int t0;
    int nreq;
    int r;
    logic [39:0] bad;

    rst_ni = 1'b0; en_i = 1'b1; busy_i = 1'b0; done_i = 1'b0; frame_i = '0;
    m_tol = 0; m_show_t = 0; m_cyc_start = 0;
    model_reset();
    step(); step();
    chk("rst_req", 32'(req_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_page", 32'(page_o), 32'h2);
    chk("rst_err", 32'(err_cnt_o), 32'd0);
    rst_ni = 1'b1;
    m_next_req = cyc + 1;

    // first read right after reset: known good frame
    do_attempt(0, 5, 40'h3700_1A00_51, 0);
    step_to(m_show_t + PAGE - 1);
    chk("page_hum_hold", 32'(page_o), 32'(exp_page()));
    step();
    chk("page_toggle", 32'(page_o), 32'(exp_page()));

    // periodicity, including done on the timeout terminal cycle and minimum latency
    do_attempt(0, TMO, mk_frame(1), 0);
    do_attempt(0, 2, mk_frame(1), 0);

    // persistent bad checksum: four attempts then cycle failure
    bad = 40'h3700_1A00_50;
    for (int a = 0; a < 4; a++) do_attempt(0, $urandom_range(2, TMO), bad, 0);

    // timeout followed by a good retry
    do_attempt(1, 0, '0, 0);
    do_attempt(0, 7, 40'h2800_1900_41, 0);

    // randomized read cycles
    for (int c = 0; c < 8; c++) begin
      for (int a = 0; a < 4; a++) begin
        r = $urandom_range(0, 9);
        if (r < 5)       do_attempt(0, $urandom_range(2, TMO), mk_frame(1), 0);
        else if (r < 8)  do_attempt(0, $urandom_range(2, TMO), mk_frame(0), 0);
        else if (r == 8) do_attempt(1, 0, '0, 0);
        else             do_attempt(0, $urandom_range(TMO + 1, TMO + 5), mk_frame(1), 0);
        if (m_retry == 0) break;
      end
    end

    // enable dropped mid-transaction
    do_attempt(0, 6, mk_frame(1), 1);
    nreq = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (req_o) nreq++;
    end
    chk("no_req_when_disabled", 32'(nreq), 32'd0);
    en_i = 1'b1;
    m_next_req = cyc + 1;
    m_tol = 1;
    do_attempt(0, 4, mk_frame(1), 0);

    // reset during WAIT_DONE
    wait_req(t0);
    chk("req_time_pre_rst", 32'(t0), 32'(m_next_req));
    step_to(t0 + 3);
    rst_ni = 1'b0;
    #1;
    model_reset();
    chk("arst_temp", 32'(temp_o), 32'd0);
    chk("arst_hum", 32'(hum_o), 32'd0);
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_led", 32'(led_o), 32'd0);
    chk("arst_err", 32'(err_cnt_o), 32'd0);
    chk("arst_fail", 32'(fail_o), 32'd0);
    chk("arst_page", 32'(page_o), 32'h2);
    step(); step();
    rst_ni = 1'b1;
    m_next_req = cyc + 1;
    m_tol = 1;
    do_attempt(0, 9, 40'h3700_1A00_51, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
